// File: rtl/zreg_stage.sv
// Z register stage: captures ALU results into ZLO/ZHI or runs a sequential signed Booth multiply.
// Define ZSTAGE_RADIX4_EN to build the radix-4 Booth datapath (WIDTH must be even); default is radix-2.
module zreg_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [4:0]       alu_control,
  input  logic [WIDTH-1:0] zlow_in,
  input  logic [WIDTH-1:0] zhigh_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             z_in,
  input  logic             zlow_out_en,
  input  logic             zhigh_out_en,
  output logic [WIDTH-1:0] zlow_out,
  output logic [WIDTH-1:0] zhigh_out,
  output logic [WIDTH-1:0] z_bus_out,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] OP_MUL = 5'b01110;
`ifdef ZSTAGE_RADIX4_EN
  localparam int ITERS = WIDTH / 2;
`else
  localparam int ITERS = WIDTH;
`endif
  localparam int CW = $clog2(ITERS + 1);

  typedef enum logic {IDLE, MULT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mcand, acc, mplier;
  logic             q_m1;
  logic [CW-1:0]    iter;
  logic [WIDTH-1:0] zlo, zhi;
  logic             done_q;
  logic             start, capture, last;
  logic [WIDTH-1:0] acc_next, mplier_next;
  logic             q_m1_next;

  assign start   = (state == IDLE) && z_in && (alu_control == OP_MUL);
  assign capture = (state == IDLE) && z_in && (alu_control != OP_MUL);
  assign last    = (state == MULT) && (iter == CW'(ITERS - 1));

  // The sum is kept one/two bits wider than acc so a most-negative multiplicand cannot overflow.
`ifdef ZSTAGE_RADIX4_EN
  logic [WIDTH+1:0] m_ext, sum;
  always_comb begin
    m_ext = {{2{mcand[WIDTH-1]}}, mcand};
    sum   = {{2{acc[WIDTH-1]}}, acc};
    unique case ({mplier[1:0], q_m1})
      3'b001, 3'b010: sum = sum + m_ext;
      3'b011:         sum = sum + (m_ext << 1);
      3'b100:         sum = sum - (m_ext << 1);
      3'b101, 3'b110: sum = sum - m_ext;
      default:        sum = sum;
    endcase
    acc_next    = sum[WIDTH+1:2];
    mplier_next = {sum[1:0], mplier[WIDTH-1:2]};
    q_m1_next   = mplier[1];
  end
`else
  logic [WIDTH:0] m_ext, sum;
  always_comb begin
    m_ext = {mcand[WIDTH-1], mcand};
    sum   = {acc[WIDTH-1], acc};
    unique case ({mplier[0], q_m1})
      2'b01:   sum = sum + m_ext;
      2'b10:   sum = sum - m_ext;
      default: sum = sum;
    endcase
    acc_next    = sum[WIDTH:1];
    mplier_next = {sum[0], mplier[WIDTH-1:1]};
    q_m1_next   = mplier[0];
  end
`endif

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = MULT;
      MULT:    if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MULT);
  end

  // Z is only written by a plain capture or the final Booth iteration, never by partial products.
  always_ff @(posedge clock) begin
    if (clear) begin
      zlo    <= '0;
      zhi    <= '0;
      done_q <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      q_m1   <= 1'b0;
      iter   <= '0;
    end else begin
      done_q <= 1'b0;
      if (capture) begin
        zlo    <= zlow_in;
        zhi    <= zhigh_in;
        done_q <= 1'b1;
      end
      if (start) begin
        mcand  <= y_in;
        mplier <= bus_in;
        acc    <= '0;
        q_m1   <= 1'b0;
        iter   <= '0;
      end
      if (state == MULT) begin
        acc    <= acc_next;
        mplier <= mplier_next;
        q_m1   <= q_m1_next;
        iter   <= iter + CW'(1);
        if (last) begin
          zhi    <= acc_next;
          zlo    <= mplier_next;
          done_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    z_bus_out = '0;
    if (zlow_out_en)       z_bus_out = zlo;
    else if (zhigh_out_en) z_bus_out = zhi;
  end

  assign zlow_out  = zlo;
  assign zhigh_out = zhi;
  assign done      = done_q;

endmodule

// File: tb/tb_zreg_stage.sv
// Self-checking bench for zreg_stage: vector table plus scoreboard, and hand sequences for
// held-off strobes, mid-multiply clear and bus selection.
module tb_zreg_stage;
  localparam int W = 32;
`ifdef ZSTAGE_RADIX4_EN
  localparam int MUL_CYCLES = W / 2;
`else
  localparam int MUL_CYCLES = W;
`endif
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam int NVEC = 12;

  logic         clock, clear, z_in, zlow_out_en, zhigh_out_en, busy, done;
  logic [4:0]   alu_control;
  logic [W-1:0] zlow_in, zhigh_in, y_in, bus_in, zlow_out, zhigh_out, z_bus_out;

  zreg_stage #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .alu_control(alu_control),
    .zlow_in(zlow_in), .zhigh_in(zhigh_in), .y_in(y_in), .bus_in(bus_in),
    .z_in(z_in), .zlow_out_en(zlow_out_en), .zhigh_out_en(zhigh_out_en),
    .zlow_out(zlow_out), .zhigh_out(zhigh_out), .z_bus_out(z_bus_out),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]     op;
    logic [W-1:0]   y, bus, zl, zh;
    logic [2*W-1:0] exp_z;
    int             exp_busy;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] z;
    int             busy_cycles;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[NVEC];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea, eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  function automatic vec_t mk_mul(input logic [W-1:0] y, input logic [W-1:0] b, input logic [63:0] z);
    vec_t v;
    v.op = OP_MUL; v.y = y; v.bus = b; v.zl = 32'h5A5A5A5A; v.zh = 32'hA5A5A5A5;
    v.exp_z = z; v.exp_busy = MUL_CYCLES;
    return v;
  endfunction

  function automatic vec_t mk_cap(input logic [4:0] op, input logic [W-1:0] zl, input logic [W-1:0] zh);
    vec_t v;
    v.op = op; v.y = 32'h0000_0003; v.bus = 32'h0000_0004; v.zl = zl; v.zh = zh;
    v.exp_z = {zh, zl}; v.exp_busy = 0;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clock);
    alu_control = v.op;
    y_in = v.y;
    bus_in = v.bus;
    zlow_in = v.zl;
    zhigh_in = v.zh;
    z_in = 1'b1;
    e.z = v.exp_z;
    e.busy_cycles = v.exp_busy;
    sb.push_back(e);
    @(negedge clock);
    z_in = 1'b0;
    alu_control = 5'd0;
  endtask

  task automatic checkOutput(input string name);
    int   busy_cnt = 0;
    int   guard = 0;
    exp_t e;
    while (!done && guard < 200) begin
      if (busy) busy_cnt++;
      @(negedge clock);
      guard++;
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s_timeout: got no done within 200 cycles, expected done", name);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare({name, "_z"}, {zhigh_out, zlow_out}, e.z);
      compare({name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.busy_cycles));
    end
    compare({name, "_busy_at_done"}, 64'(busy), 64'(0));
    @(negedge clock);
    compare({name, "_done_one_cycle"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [63:0] held;
    int          pulses;
    vec_t        v;

    vecs[0]  = mk_cap(OP_ADD, 32'h0000_0007, 32'h0000_0000);
    vecs[1]  = mk_mul(32'h0000_0003, 32'hFFFF_FFFE, 64'hFFFFFFFF_FFFFFFFA);
    vecs[2]  = mk_mul(32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000);
    vecs[3]  = mk_mul(32'h7FFF_FFFF, 32'h8000_0000, 64'hC0000000_80000000);
    vecs[4]  = mk_mul(32'h8000_0000, 32'h0000_0001, 64'hFFFFFFFF_80000000);
    vecs[5]  = mk_mul(32'h0000_0000, 32'h1234_5678, 64'h0);
    vecs[6]  = mk_cap(5'b00100, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    vecs[7]  = mk_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1);
    for (int i = 8; i < NVEC; i++) begin
      v.y = $urandom;
      v.bus = $urandom;
      vecs[i] = mk_mul(v.y, v.bus, mul_model(v.y, v.bus));
    end

    // clear asserted together with a capture strobe must win
    clear = 1'b1; z_in = 1'b1; alu_control = OP_ADD;
    zlow_in = 32'hAAAA_AAAA; zhigh_in = 32'h5555_5555; y_in = '0; bus_in = '0;
    zlow_out_en = 1'b0; zhigh_out_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    compare("reset_zlo", 64'(zlow_out), 64'(0));
    compare("reset_zhi", 64'(zhigh_out), 64'(0));
    compare("reset_busy", 64'(busy), 64'(0));
    compare("reset_done", 64'(done), 64'(0));
    clear = 1'b0; z_in = 1'b0; alu_control = 5'd0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // ADD strobe during a multiply is ignored; Z holds until the final write
    held = {zhigh_out, zlow_out};
    v = mk_mul(32'h0000_0005, 32'hFFFF_FFF9, 64'hFFFFFFFF_FFFFFFDD);
    v.exp_busy = MUL_CYCLES - 5;
    applyStimulus(v);
    repeat (4) @(negedge clock);
    alu_control = OP_ADD; zlow_in = 32'h0000_1234; zhigh_in = 32'h0000_5678; z_in = 1'b1;
    @(negedge clock);
    z_in = 1'b0; alu_control = 5'd0;
    compare("mult_hold_z", {zhigh_out, zlow_out}, held);
    checkOutput("ignore_add");

    // clear mid-multiply aborts without a done pulse
    @(negedge clock);
    alu_control = OP_MUL; y_in = 32'h0000_0009; bus_in = 32'h0000_000B; z_in = 1'b1;
    @(negedge clock);
    z_in = 1'b0; alu_control = 5'd0;
    repeat (8) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    compare("abort_z", {zhigh_out, zlow_out}, 64'h0);
    compare("abort_busy", 64'(busy), 64'(0));
    pulses = 0;
    repeat (MUL_CYCLES + 8) begin
      if (done) pulses++;
      @(negedge clock);
    end
    compare("abort_no_done", 64'(pulses), 64'(0));
    compare("abort_z_stays", {zhigh_out, zlow_out}, 64'h0);
    applyStimulus(mk_cap(OP_ADD, 32'h1111_1111, 32'h2222_2222));
    checkOutput("after_abort");

    // bus select priority
    zlow_out_en = 1'b1; zhigh_out_en = 1'b1; #1;
    compare("bus_both", 64'(z_bus_out), 64'h1111_1111);
    zlow_out_en = 1'b1; zhigh_out_en = 1'b0; #1;
    compare("bus_lo", 64'(z_bus_out), 64'h1111_1111);
    zlow_out_en = 1'b0; zhigh_out_en = 1'b1; #1;
    compare("bus_hi", 64'(z_bus_out), 64'h2222_2222);
    zlow_out_en = 1'b0; zhigh_out_en = 1'b0; #1;
    compare("bus_none", 64'(z_bus_out), 64'h0);

    compare("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
